char_pixel_serialiser: RTL and testbench

//  Consumer end of the VGA character-clock scheme: accepts one text-mode character cell
//  per char period (glyph row + attributes) via valid/ready and emits one colour index per

---
 rtl/char_pixel_serialiser_if.sv | 43 ++++
 rtl/char_pixel_serialiser.sv | 168 ++++++++++++++++
 tb/tb_char_pixel_serialiser.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/char_pixel_serialiser_if.sv
// char_pixel_serialiser_if
//   Bundles the character-cell handshake (cell in) and the pixel stream (pixel out)
//   of the character pixel serialiser.
//   slave  modport: used by the serialiser (consumes cells, produces pixels).
//   master modport: used by whoever feeds cells and watches the pixel stream.
//   Signals:
//     mode8_i        1 = 8-pixel characters, 0 = 9-pixel characters
//     valid_i        character cell offered
//     ready_o        cell accepted when valid_i & ready_o at the rising edge
//     glyph_i        glyph row, bit 7 = leftmost pixel
//     fg_i / bg_i    foreground / background colour indices
//     dup9_i         9th pixel repeats glyph bit 0 (line graphics)
//     cursor_i       swap fg/bg for this cell
//     pixel_o        current pixel colour index (registered)
//     pixel_valid_o  pixel_o valid this cycle
//     char_start_o   high on pixel 0 of each character
//     underrun_o     one-cycle pulse: character ended with no next cell held
interface char_pixel_serialiser_if #(
  parameter int COLOUR_W = 4
);
  logic                mode8_i;
  logic                valid_i;
  logic                ready_o;
  logic [7:0]          glyph_i;
  logic [COLOUR_W-1:0] fg_i;
  logic [COLOUR_W-1:0] bg_i;
  logic                dup9_i;
  logic                cursor_i;
  logic [COLOUR_W-1:0] pixel_o;
  logic                pixel_valid_o;
  logic                char_start_o;
  logic                underrun_o;

  modport slave (
    input  mode8_i, valid_i, glyph_i, fg_i, bg_i, dup9_i, cursor_i,
    output ready_o, pixel_o, pixel_valid_o, char_start_o, underrun_o
  );

  modport master (
    output mode8_i, valid_i, glyph_i, fg_i, bg_i, dup9_i, cursor_i,
    input  ready_o, pixel_o, pixel_valid_o, char_start_o, underrun_o
  );
endinterface

// File: rtl/char_pixel_serialiser.sv
// char_pixel_serialiser
//   Consumer end of the VGA character-clock scheme. Accepts one text-mode character
//   cell per character period over valid/ready and emits one colour index per pixel
//   clock, 8 or 9 pixels per character. A one-entry hold register sits in front of
//   the pixel shifter so a continuous stream runs without bubbles.
//   Ports:
//     clock_i  pixel clock (only clock)
//     reset_i  synchronous, active-high reset
//     cell_if  slave side of char_pixel_serialiser_if (cell handshake + pixel stream)
module char_pixel_serialiser #(
  parameter int COLOUR_W = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  char_pixel_serialiser_if.slave  cell_if
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_next;

  // Hold register: the next cell waiting for the shifter
  logic                hold_valid;
  logic [7:0]          hold_glyph;
  logic [COLOUR_W-1:0] hold_fg;
  logic [COLOUR_W-1:0] hold_bg;
  logic                hold_dup9;
  logic                hold_cursor;

  // Shifter: the character currently being drawn
  logic [7:0]          pattern;
  logic [COLOUR_W-1:0] fg_s;
  logic [COLOUR_W-1:0] bg_s;
  logic                dup9_s;
  logic [3:0]          last_idx;
  logic [3:0]          cnt;
  logic [3:0]          next_cnt;

  // Registered outputs
  logic [COLOUR_W-1:0] pixel_q;
  logic                pixel_valid_q;
  logic                char_start_q;
  logic                underrun_q;

  logic                at_last;
  logic                load;
  logic                accept;
  logic [COLOUR_W-1:0] load_fg;
  logic [COLOUR_W-1:0] load_bg;

  // Colour of pixel idx of a character. Pixels 0..7 map glyph bits 7..0
  // (7-k equals the bitwise inverse of k in three bits); pixel 8 is either a copy
  // of bit 0 (line graphics) or plain background.
  function automatic logic [COLOUR_W-1:0] pixel_colour(
    input logic [7:0]          pat,
    input logic [3:0]          idx,
    input logic                dup9,
    input logic [COLOUR_W-1:0] fg,
    input logic [COLOUR_W-1:0] bg
  );
    logic bit_on;
    if (idx < 4'd8) begin
      bit_on = pat[~idx[2:0]];
    end else begin
      bit_on = dup9 & pat[0];
    end
    return bit_on ? fg : bg;
  endfunction

  // Load happens when a cell is held and the shifter is either idle or on its last
  // pixel, so the next character follows the current one without a gap.
  always_comb begin
    state_next = state;
    at_last    = (state == SHIFT) && (cnt == last_idx);
    load       = hold_valid && ((state == IDLE) || at_last);
    if (load) begin
      state_next = SHIFT;
    end else if (at_last) begin
      state_next = IDLE;
    end
  end

  // The hold slot frees up in the same cycle it is loaded, allowing load+accept together
  assign cell_if.ready_o = ~hold_valid | load;
  assign accept          = cell_if.valid_i & cell_if.ready_o;

  // Cursor inverts the cell by swapping its colours as it enters the shifter
  assign load_fg  = hold_cursor ? hold_bg : hold_fg;
  assign load_bg  = hold_cursor ? hold_fg : hold_bg;
  assign next_cnt = cnt + 4'd1;

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hold register: capture on accept, release on load; accept wins when both happen
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hold_valid  <= 1'b0;
      hold_glyph  <= '0;
      hold_fg     <= '0;
      hold_bg     <= '0;
      hold_dup9   <= 1'b0;
      hold_cursor <= 1'b0;
    end else if (accept) begin
      hold_valid  <= 1'b1;
      hold_glyph  <= cell_if.glyph_i;
      hold_fg     <= cell_if.fg_i;
      hold_bg     <= cell_if.bg_i;
      hold_dup9   <= cell_if.dup9_i;
      hold_cursor <= cell_if.cursor_i;
    end else if (load) begin
      hold_valid  <= 1'b0;
    end
  end

  // Shifter and registered pixel outputs. Character width is fixed at load so a
  // mid-character change of mode8_i only affects the next character.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pattern       <= '0;
      fg_s          <= '0;
      bg_s          <= '0;
      dup9_s        <= 1'b0;
      last_idx      <= '0;
      cnt           <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      char_start_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      char_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      if (load) begin
        pattern       <= hold_glyph;
        fg_s          <= load_fg;
        bg_s          <= load_bg;
        dup9_s        <= hold_dup9;
        cnt           <= 4'd0;
        last_idx      <= cell_if.mode8_i ? 4'd7 : 4'd8;
        char_start_q  <= 1'b1;
        pixel_valid_q <= 1'b1;
        pixel_q       <= pixel_colour(hold_glyph, 4'd0, hold_dup9, load_fg, load_bg);
      end else if ((state == SHIFT) && (cnt != last_idx)) begin
        cnt     <= next_cnt;
        pixel_q <= pixel_colour(pattern, next_cnt, dup9_s, fg_s, bg_s);
      end else if (at_last) begin
        pixel_valid_q <= 1'b0;
        pixel_q       <= '0;
        underrun_q    <= 1'b1;
      end
    end
  end

  assign cell_if.pixel_o       = pixel_q;
  assign cell_if.pixel_valid_o = pixel_valid_q;
  assign cell_if.char_start_o  = char_start_q;
  assign cell_if.underrun_o    = underrun_q;

endmodule

// File: tb/tb_char_pixel_serialiser.sv
// tb_char_pixel_serialiser
//   Self-checking bench for char_pixel_serialiser. The reference model is a pixel
//   schedule: every accepted cell is expanded into colours placed on the clock edges
//   where they must appear, with a cell starting one edge after acceptance or right
//   after the previous character's last pixel, whichever is later. Outputs and
//   ready_o are compared against that schedule on every edge.
module tb_char_pixel_serialiser;
  localparam int COLOUR_W = 4;

  logic clock_i = 1'b0;
  logic reset_i;

  always #5 clock_i = ~clock_i;

  char_pixel_serialiser_if #(.COLOUR_W(COLOUR_W)) cell_if ();

  char_pixel_serialiser #(.COLOUR_W(COLOUR_W)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .cell_if (cell_if)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Schedule: edge index -> expected colour / character start marker
  int exp_colour [int];
  bit exp_start  [int];
  int last_end   = -10;

  // Accepted cell not yet started, with the edge at which it must start
  bit         have_pending = 1'b0;
  int         pending_start = 0;
  logic [7:0] pend_glyph;
  logic [3:0] pend_fg;
  logic [3:0] pend_bg;
  bit         pend_dup9;
  bit         pend_cursor;

  bit accepted_now;
  int obs_log [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  // Place all pixels of the pending cell on the schedule starting at edge s
  task automatic expand_cell(input int s, input bit mode8);
    int         len;
    logic [3:0] fg_e;
    logic [3:0] bg_e;
    bit         bit_on;
    len  = mode8 ? 8 : 9;
    fg_e = pend_cursor ? pend_bg : pend_fg;
    bg_e = pend_cursor ? pend_fg : pend_bg;
    for (int k = 0; k < len; k++) begin
      if (k < 8) bit_on = pend_glyph[7-k];
      else       bit_on = pend_dup9 && pend_glyph[0];
      exp_colour[s+k] = bit_on ? int'(fg_e) : int'(bg_e);
    end
    exp_start[s] = 1'b1;
    last_end = s + len - 1;
  endtask

  // One clock edge: predict before the edge, compare after it
  task automatic step();
    bit exp_ready;
    int exp_pix;
    @(negedge clock_i);
    exp_ready = !(have_pending && (pending_start > edge_n));
    if (edge_n > 0) check_output("ready", 32'(cell_if.ready_o), 32'(exp_ready));
    accepted_now = 1'b0;
    if (reset_i) begin
      exp_colour.delete();
      exp_start.delete();
      have_pending = 1'b0;
      last_end = edge_n;
    end else begin
      if (have_pending && (pending_start == edge_n)) begin
        expand_cell(edge_n, cell_if.mode8_i);
        have_pending = 1'b0;
      end
      if (cell_if.valid_i && exp_ready) begin
        accepted_now  = 1'b1;
        have_pending  = 1'b1;
        pending_start = (edge_n + 1 > last_end + 1) ? edge_n + 1 : last_end + 1;
        pend_glyph    = cell_if.glyph_i;
        pend_fg       = cell_if.fg_i;
        pend_bg       = cell_if.bg_i;
        pend_dup9     = cell_if.dup9_i;
        pend_cursor   = cell_if.cursor_i;
      end
    end
    @(posedge clock_i);
    #1;
    exp_pix = exp_colour.exists(edge_n) ? exp_colour[edge_n] : 0;
    check_output("pixel_valid", 32'(cell_if.pixel_valid_o), 32'(exp_colour.exists(edge_n)));
    check_output("pixel", 32'(cell_if.pixel_o), 32'(exp_pix));
    check_output("char_start", 32'(cell_if.char_start_o), 32'(exp_start.exists(edge_n)));
    check_output("underrun", 32'(cell_if.underrun_o),
                 32'(exp_colour.exists(edge_n - 1) && !exp_colour.exists(edge_n)));
    if (cell_if.pixel_valid_o) obs_log.push_back(int'(cell_if.pixel_o));
    edge_n++;
  endtask

  // Offer one cell and keep valid high until it is taken (bounded)
  task automatic apply_stimulus(input logic [7:0] glyph, input logic [3:0] fg,
                                input logic [3:0] bg, input bit dup9, input bit cursor);
    bit done;
    cell_if.glyph_i  = glyph;
    cell_if.fg_i     = fg;
    cell_if.bg_i     = bg;
    cell_if.dup9_i   = dup9;
    cell_if.cursor_i = cursor;
    cell_if.valid_i  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = accepted_now;
    end
    check_output("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    cell_if.valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_log(input string tag, input int exp_vals [$]);
    check_output({tag, "_count"}, 32'(obs_log.size()), 32'(exp_vals.size()));
    for (int i = 0; i < exp_vals.size() && i < obs_log.size(); i++)
      check_output(tag, 32'(obs_log[i]), 32'(exp_vals[i]));
  endtask

  initial begin
    reset_i          = 1'b1;
    cell_if.mode8_i  = 1'b1;
    cell_if.valid_i  = 1'b0;
    cell_if.glyph_i  = 8'h00;
    cell_if.fg_i     = 4'h0;
    cell_if.bg_i     = 4'h0;
    cell_if.dup9_i   = 1'b0;
    cell_if.cursor_i = 1'b0;
    repeat (3) step();
    reset_i = 1'b0;
    step();

    $display("[TB] 8-pixel glyph 0xA5");
    obs_log.delete();
    apply_stimulus(8'hA5, 4'hF, 4'h1, 1'b0, 1'b0);
    idle(12);
    check_log("glyph_a5", '{15, 1, 15, 1, 1, 15, 1, 15});

    $display("[TB] 9-pixel dup9 on and off");
    cell_if.mode8_i = 1'b0;
    obs_log.delete();
    apply_stimulus(8'h01, 4'hF, 4'h1, 1'b1, 1'b0);
    apply_stimulus(8'h01, 4'hF, 4'h1, 1'b0, 1'b0);
    idle(22);
    check_log("dup9", '{1, 1, 1, 1, 1, 1, 1, 15, 15, 1, 1, 1, 1, 1, 1, 1, 15, 1});

    $display("[TB] four back-to-back cells");
    cell_if.mode8_i = 1'b1;
    obs_log.delete();
    for (int i = 0; i < 4; i++)
      apply_stimulus(8'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
    idle(20);
    check_output("stream_len", 32'(obs_log.size()), 32'd32);

    $display("[TB] cursor swap");
    obs_log.delete();
    apply_stimulus(8'hF0, 4'hF, 4'h1, 1'b0, 1'b1);
    idle(12);
    check_log("cursor", '{1, 1, 1, 1, 15, 15, 15, 15});

    $display("[TB] mode change mid-character");
    cell_if.mode8_i = 1'b0;
    obs_log.delete();
    apply_stimulus(8'h81, 4'h7, 4'h2, 1'b1, 1'b0);
    cell_if.valid_i = 1'b0;
    repeat (3) step();
    cell_if.mode8_i = 1'b1;
    idle(12);
    check_output("mode_hold_len", 32'(obs_log.size()), 32'd9);

    $display("[TB] reset mid-character with hold full");
    apply_stimulus(8'h3C, 4'hA, 4'h5, 1'b0, 1'b0);
    apply_stimulus(8'hC3, 4'hB, 4'h6, 1'b0, 1'b0);
    cell_if.valid_i = 1'b0;
    repeat (3) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    idle(12);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      cell_if.valid_i  = ($urandom_range(0, 3) != 0);
      cell_if.glyph_i  = 8'($urandom);
      cell_if.fg_i     = 4'($urandom);
      cell_if.bg_i     = 4'($urandom);
      cell_if.dup9_i   = 1'($urandom);
      cell_if.cursor_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) cell_if.mode8_i = ~cell_if.mode8_i;
      reset_i = ($urandom_range(0, 299) == 0);
      step();
    end
    reset_i = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
